branch_redirect_ctl: RTL and testbench

BRANCH_REDIRECT_CTL -- requirements
Module: branch_redirect_ctl

---
 rtl/branch_redirect_ctl.sv | 124 ++++++++++++
 tb/tb_branch_redirect_ctl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctl.sv
// Branch redirect controller: offers a branch target to fetch, flushes and squashes
// younger work, and arbitrates the shared register-file write port (link over ALU).
module branch_redirect_ctl #(
   parameter int unsigned SQUASH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        br_do_jump,
   input  logic [63:0] br_jump_pc,
   input  logic        br_r63_update,
   input  logic [63:0] br_r63,
   input  logic        stall,
   output logic        fetch_redirect_valid,
   output logic [63:0] fetch_redirect_pc,
   input  logic        fetch_redirect_ack,
   output logic        flush,
   output logic        squash_active,
   output logic        dispatch_hold,
   input  logic        alu_wb_req,
   input  logic [5:0]  alu_wb_reg,
   input  logic [63:0] alu_wb_data,
   output logic        alu_wb_grant,
   output logic        rf_we,
   output logic [5:0]  rf_waddr,
   output logic [63:0] rf_wdata,
   output logic        err_overrun
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      SQUASH   = 2'd2
   } state_t;

   localparam logic [3:0] COUNT_LOAD = 4'(SQUASH_CYCLES - 1);

   state_t      state;
   logic [3:0]  count;
   logic        link_pending;
   logic [63:0] link_data;
   logic        link_drain;
   logic        jump_overrun;
   logic        link_overrun;

   assign link_drain   = link_pending & ~stall;
   assign jump_overrun = br_do_jump & (state != IDLE);
   assign link_overrun = br_r63_update & link_pending & ~link_drain;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would make ordering between blocks matter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         count             <= '0;
         flush             <= 1'b0;
         fetch_redirect_pc <= '0;
      end else begin
         flush <= 1'b0;
         case (state)
            IDLE: begin
               if (br_do_jump) begin
                  fetch_redirect_pc <= br_jump_pc;
                  flush             <= 1'b1;
                  state             <= REDIRECT;
               end
            end
            REDIRECT: begin
               if (fetch_redirect_ack) begin
                  count <= COUNT_LOAD;
                  state <= SQUASH;
               end
            end
            SQUASH: begin
               if (!stall) begin
                  if (count == 4'd0) state <= IDLE;
                  else               count <= count - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A write arriving in the same cycle the buffer drains is a reload, not an overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         link_pending <= 1'b0;
         link_data    <= '0;
      end else if (br_r63_update) begin
         link_pending <= 1'b1;
         link_data    <= br_r63;
      end else if (link_drain) begin
         link_pending <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_overrun <= 1'b0;
      else        err_overrun <= err_overrun | jump_overrun | link_overrun;
   end

   assign fetch_redirect_valid = (state == REDIRECT);
   assign squash_active        = (state != IDLE);
   assign dispatch_hold        = (state != IDLE);
   assign alu_wb_grant         = alu_wb_req & ~link_pending & ~stall;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      if (link_drain) begin
         rf_we    = 1'b1;
         rf_waddr = 6'd63;
         rf_wdata = link_data;
      end else if (alu_wb_grant) begin
         rf_we    = 1'b1;
         rf_waddr = alu_wb_reg;
         rf_wdata = alu_wb_data;
      end
   end

endmodule

// File: tb/tb_branch_redirect_ctl.sv
// Self-checking bench for branch_redirect_ctl: directed vector table, hand-written
// corner sequences, and randomized traffic against a cycle-count reference model.
module tb_branch_redirect_ctl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        br_do_jump;
   logic [63:0] br_jump_pc;
   logic        br_r63_update;
   logic [63:0] br_r63;
   logic        stall;
   logic        fetch_redirect_ack;
   logic        alu_wb_req;
   logic [5:0]  alu_wb_reg;
   logic [63:0] alu_wb_data;

   logic        valid,  flush,  squash,  hold,  grant,  we,  err;
   logic [63:0] rpc, wdata;
   logic [5:0]  waddr;
   logic        valid1, flush1, squash1, hold1, grant1, we1, err1;
   logic [63:0] rpc1, wdata1;
   logic [5:0]  waddr1;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   branch_redirect_ctl #(.SQUASH_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .br_do_jump(br_do_jump), .br_jump_pc(br_jump_pc),
      .br_r63_update(br_r63_update), .br_r63(br_r63), .stall(stall),
      .fetch_redirect_valid(valid), .fetch_redirect_pc(rpc),
      .fetch_redirect_ack(fetch_redirect_ack), .flush(flush),
      .squash_active(squash), .dispatch_hold(hold),
      .alu_wb_req(alu_wb_req), .alu_wb_reg(alu_wb_reg), .alu_wb_data(alu_wb_data),
      .alu_wb_grant(grant), .rf_we(we), .rf_waddr(waddr), .rf_wdata(wdata),
      .err_overrun(err)
   );

   branch_redirect_ctl #(.SQUASH_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .br_do_jump(br_do_jump), .br_jump_pc(br_jump_pc),
      .br_r63_update(br_r63_update), .br_r63(br_r63), .stall(stall),
      .fetch_redirect_valid(valid1), .fetch_redirect_pc(rpc1),
      .fetch_redirect_ack(fetch_redirect_ack), .flush(flush1),
      .squash_active(squash1), .dispatch_hold(hold1),
      .alu_wb_req(alu_wb_req), .alu_wb_reg(alu_wb_reg), .alu_wb_data(alu_wb_data),
      .alu_wb_grant(grant1), .rf_we(we1), .rf_waddr(waddr1), .rf_wdata(wdata1),
      .err_overrun(err1)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      br_do_jump = 1'b0; br_jump_pc = '0; br_r63_update = 1'b0; br_r63 = '0;
      stall = 1'b0; fetch_redirect_ack = 1'b0;
      alu_wb_req = 1'b0; alu_wb_reg = '0; alu_wb_data = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " valid"},  64'(valid),  64'd0);
      check({tag, " flush"},  64'(flush),  64'd0);
      check({tag, " squash"}, 64'(squash), 64'd0);
      check({tag, " hold"},   64'(hold),   64'd0);
      check({tag, " rf_we"},  64'(we),     64'd0);
      check({tag, " grant"},  64'(grant),  64'd0);
      check({tag, " err"},    64'(err),    64'd0);
      check({tag, " pc"},     rpc,         64'd0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        jump;  logic [63:0] jpc; logic ack; logic stl;
      logic        upd;   logic [63:0] r63; logic areq; logic [5:0] areg; logic [63:0] adata;
      logic        e_flush; logic e_valid; logic [63:0] e_pc; logic e_sq;
      logic        e_we;  logic [5:0] e_waddr; logic [63:0] e_wdata; logic e_grant;
   } vec_t;

   vec_t vecs [15];

   // ---------------- reference model ----------------
   bit          m_redirect;
   int          m_left;
   bit          m_flush;
   bit          m_err;
   logic [63:0] m_pc;
   logic [63:0] m_link [$];

   task automatic model_reset();
      m_redirect = 0; m_left = 0; m_flush = 0; m_err = 0; m_pc = '0;
      m_link.delete();
   endtask

   task automatic model_check(input int cyc);
      logic        e_we, e_grant;
      logic [5:0]  e_addr;
      logic [63:0] e_data;
      e_we = 0; e_addr = '0; e_data = '0;
      e_grant = alu_wb_req && (m_link.size() == 0) && !stall;
      if (m_link.size() != 0 && !stall) begin
         e_we = 1; e_addr = 6'd63; e_data = m_link[0];
      end else if (e_grant) begin
         e_we = 1; e_addr = alu_wb_reg; e_data = alu_wb_data;
      end
      check($sformatf("rnd%0d valid", cyc),  64'(valid),  64'(m_redirect));
      check($sformatf("rnd%0d flush", cyc),  64'(flush),  64'(m_flush));
      check($sformatf("rnd%0d squash", cyc), 64'(squash), 64'(m_redirect || m_left > 0));
      check($sformatf("rnd%0d hold", cyc),   64'(hold),   64'(m_redirect || m_left > 0));
      if (m_redirect) check($sformatf("rnd%0d pc", cyc), rpc, m_pc);
      check($sformatf("rnd%0d we", cyc),     64'(we),     64'(e_we));
      check($sformatf("rnd%0d waddr", cyc),  64'(waddr),  64'(e_addr));
      check($sformatf("rnd%0d wdata", cyc),  wdata,       e_data);
      check($sformatf("rnd%0d grant", cyc),  64'(grant),  64'(e_grant));
      check($sformatf("rnd%0d err", cyc),    64'(err),    64'(m_err));
   endtask

   // Advances the model across one rising edge using the inputs currently applied.
   task automatic model_step();
      bit idle;
      bit nf;
      idle = !m_redirect && m_left == 0;
      nf = 0;
      if (m_redirect) begin
         if (fetch_redirect_ack) begin m_redirect = 0; m_left = 2; end
      end else if (m_left > 0) begin
         if (!stall) m_left--;
      end else if (br_do_jump) begin
         m_redirect = 1; m_pc = br_jump_pc; nf = 1;
      end
      if (br_do_jump && !idle) m_err = 1;
      m_flush = nf;
      if (m_link.size() != 0 && !stall) void'(m_link.pop_front());
      if (br_r63_update) begin
         if (m_link.size() != 0) m_err = 1;
         m_link.delete();
         m_link.push_back(br_r63);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b1, 64'h1000, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 6'd0, 64'h0,    1'b0, 1'b0, 64'h0,    1'b0, 1'b0, 6'd0,  64'h0,    1'b0};
      vecs[1]  = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 6'd0, 64'h0,    1'b1, 1'b1, 64'h1000, 1'b1, 1'b0, 6'd0,  64'h0,    1'b0};
      vecs[2]  = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 6'd0, 64'h0,    1'b0, 1'b1, 64'h1000, 1'b1, 1'b0, 6'd0,  64'h0,    1'b0};
      vecs[3]  = '{1'b0, 64'h0,    1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 6'd0, 64'h0,    1'b0, 1'b1, 64'h1000, 1'b1, 1'b0, 6'd0,  64'h0,    1'b0};
      vecs[4]  = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 6'd0, 64'h0,    1'b0, 1'b0, 64'h0,    1'b1, 1'b0, 6'd0,  64'h0,    1'b0};
      vecs[5]  = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 6'd0, 64'h0,    1'b0, 1'b0, 64'h0,    1'b1, 1'b0, 6'd0,  64'h0,    1'b0};
      vecs[6]  = '{1'b1, 64'h2000, 1'b0, 1'b0, 1'b1, 64'h2004, 1'b1, 6'd5, 64'hAAAA, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 6'd5,  64'hAAAA, 1'b1};
      vecs[7]  = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 6'd5, 64'hAAAA, 1'b1, 1'b1, 64'h2000, 1'b1, 1'b1, 6'd63, 64'h2004, 1'b0};
      vecs[8]  = '{1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 64'h5555, 1'b1, 6'd5, 64'hAAAA, 1'b0, 1'b1, 64'h2000, 1'b1, 1'b1, 6'd5, 64'hAAAA, 1'b1};
      vecs[9]  = '{1'b0, 64'h0,    1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 6'd0, 64'h0,    1'b0, 1'b0, 64'h0,    1'b1, 1'b0, 6'd0,  64'h0,    1'b0};
      vecs[10] = '{1'b0, 64'h0,    1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 6'd0, 64'h0,    1'b0, 1'b0, 64'h0,    1'b1, 1'b0, 6'd0,  64'h0,    1'b0};
      vecs[11] = '{1'b0, 64'h0,    1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 6'd0, 64'h0,    1'b0, 1'b0, 64'h0,    1'b1, 1'b0, 6'd0,  64'h0,    1'b0};
      vecs[12] = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 6'd0, 64'h0,    1'b0, 1'b0, 64'h0,    1'b1, 1'b1, 6'd63, 64'h5555, 1'b0};
      vecs[13] = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 6'd0, 64'h0,    1'b0, 1'b0, 64'h0,    1'b1, 1'b0, 6'd0,  64'h0,    1'b0};
      vecs[14] = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 6'd0, 64'h0,    1'b0, 1'b0, 64'h0,    1'b0, 1'b0, 6'd0,  64'h0,    1'b0};

      clear_inputs();
      rst_n = 1'b0;
      #12;
      check_all_zero("reset");
      rst_n = 1'b1;

      // Directed table: redirect with late ack, link priority, stall blocking writes.
      for (int i = 0; i < 15; i++) begin
         next_cycle();
         br_do_jump = vecs[i].jump; br_jump_pc = vecs[i].jpc;
         fetch_redirect_ack = vecs[i].ack; stall = vecs[i].stl;
         br_r63_update = vecs[i].upd; br_r63 = vecs[i].r63;
         alu_wb_req = vecs[i].areq; alu_wb_reg = vecs[i].areg; alu_wb_data = vecs[i].adata;
         @(negedge clk);
         check($sformatf("vec%0d flush", i),  64'(flush),  64'(vecs[i].e_flush));
         check($sformatf("vec%0d valid", i),  64'(valid),  64'(vecs[i].e_valid));
         if (vecs[i].e_valid) check($sformatf("vec%0d pc", i), rpc, vecs[i].e_pc);
         check($sformatf("vec%0d squash", i), 64'(squash), 64'(vecs[i].e_sq));
         check($sformatf("vec%0d hold", i),   64'(hold),   64'(vecs[i].e_sq));
         check($sformatf("vec%0d rf_we", i),  64'(we),     64'(vecs[i].e_we));
         check($sformatf("vec%0d waddr", i),  64'(waddr),  64'(vecs[i].e_waddr));
         check($sformatf("vec%0d wdata", i),  wdata,       vecs[i].e_wdata);
         check($sformatf("vec%0d grant", i),  64'(grant),  64'(vecs[i].e_grant));
         check($sformatf("vec%0d err", i),    64'(err),    64'(1'b0));
      end

      // Overrun: a second jump during REDIRECT is dropped and flagged until reset.
      next_cycle(); clear_inputs(); br_do_jump = 1'b1; br_jump_pc = 64'h4000;
      next_cycle(); clear_inputs(); br_do_jump = 1'b1; br_jump_pc = 64'h3000;
      @(negedge clk);
      check("ovr pc_before", rpc, 64'h4000);
      next_cycle(); clear_inputs();
      @(negedge clk);
      check("ovr pc_kept", rpc, 64'h4000);
      check("ovr valid",   64'(valid), 64'd1);
      check("ovr err",     64'(err),   64'd1);
      fetch_redirect_ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         next_cycle(); clear_inputs();
         @(negedge clk);
         check($sformatf("ovr err_sticky%0d", i), 64'(err), 64'd1);
      end
      check("ovr idle", 64'(squash), 64'd0);
      rst_n = 1'b0;
      #1;
      check("ovr err_cleared", 64'(err), 64'd0);
      rst_n = 1'b1;

      // Zero-latency ack on the SQUASH_CYCLES=1 instance.
      next_cycle(); clear_inputs(); br_do_jump = 1'b1; br_jump_pc = 64'h8000;
      next_cycle(); clear_inputs(); fetch_redirect_ack = 1'b1;
      @(negedge clk);
      check("zl c1 valid",  64'(valid1),  64'd1);
      check("zl c1 flush",  64'(flush1),  64'd1);
      check("zl c1 pc",     rpc1,         64'h8000);
      next_cycle(); clear_inputs();
      @(negedge clk);
      check("zl c2 valid",  64'(valid1),  64'd0);
      check("zl c2 squash", 64'(squash1), 64'd1);
      next_cycle();
      @(negedge clk);
      check("zl c3 squash", 64'(squash1), 64'd0);
      check("zl c3 hold",   64'(hold1),   64'd0);
      for (int i = 0; i < 3; i++) next_cycle();

      // Reset during SQUASH with a link write pending and held by stall.
      clear_inputs(); br_do_jump = 1'b1; br_jump_pc = 64'h9000;
      next_cycle(); clear_inputs();
      fetch_redirect_ack = 1'b1; br_r63_update = 1'b1; br_r63 = 64'h7777; stall = 1'b1;
      next_cycle(); clear_inputs(); stall = 1'b1;
      @(negedge clk);
      check("rst sq_before", 64'(squash), 64'd1);
      check("rst we_before", 64'(we),     64'd0);
      #1;
      rst_n = 1'b0;
      stall = 1'b0;
      #1;
      check_all_zero("rst_mid");
      @(posedge clk); #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("rst no_link_write%0d", i), 64'(we), 64'd0);
         check($sformatf("rst idle%0d", i),          64'(squash), 64'd0);
         next_cycle();
      end

      // Randomized traffic against the reference model.
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      #3;
      rst_n = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         next_cycle();
         br_do_jump         = ($urandom_range(0, 7) == 0);
         br_jump_pc         = {$urandom, $urandom};
         fetch_redirect_ack = ($urandom_range(0, 2) == 0);
         stall              = ($urandom_range(0, 3) == 0);
         br_r63_update      = ($urandom_range(0, 4) == 0);
         br_r63             = {$urandom, $urandom};
         alu_wb_req         = $urandom_range(0, 1) == 1;
         alu_wb_reg         = 6'($urandom_range(0, 63));
         alu_wb_data        = {$urandom, $urandom};
         @(negedge clk);
         model_check(c);
         model_step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
